// File: rtl/prime_sieve_ctrl.sv
// -----------------------------------------------------------------------------
// prime_sieve_ctrl
//
// Finds every prime in [2, N-1] with the Sieve of Eratosthenes. The block owns
// an N-bit composite-flag bitmap, a candidate counter c, a mark pointer m and a
// stride. SCAN tests one candidate per cycle. Each unmarked candidate is
// streamed out as a prime. If c*c < N, MARK then flags c*c, c*c+c, ... one
// bit per cycle.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset (returns to IDLE, outputs 0)
//   Start       in   begin a run; accepted only in IDLE/DONE with En=1
//   En          in   advance enable; low freezes all state and the bitmap
//   Busy        out  run in progress (CLEAR, SCAN, MARK)
//   Done        out  run finished; held until the next accepted Start
//   PrimeValid  out  one enabled-cycle pulse: Prime carries a new prime
//   Prime       out  most recent prime found
//   PrimeCount  out  primes emitted in the current run
// -----------------------------------------------------------------------------
module prime_sieve_ctrl #(
  parameter int N      = 1024,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              En,
  output logic              Busy,
  output logic              Done,
  output logic              PrimeValid,
  output logic [ADDR_W-1:0] Prime,
  output logic [CNT_W-1:0]  PrimeCount
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_MARK  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Bitmap index width is sized to the bitmap itself, not to the value width.
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // N at the widths of the two guarded computations. No wrap-around is
  // possible at these widths.
  localparam logic [2*ADDR_W-1:0] N_SQ_CMP  = (2*ADDR_W)'(N);
  localparam logic [ADDR_W:0]     N_ADD_CMP = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0]   C_LAST    = ADDR_W'(N - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   c_q, c_d;
  logic [ADDR_W-1:0]   m_q, m_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [N-1:0]        bitmap_q, bitmap_d;
  logic [ADDR_W-1:0]   prime_q, prime_d;
  logic                pv_q, pv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2*ADDR_W-1:0] c_sq_s;
  logic [ADDR_W:0]     m_next_s;
  logic                c_last_s;
  logic                c_marked_s;

  assign c_sq_s     = {{ADDR_W{1'b0}}, c_q} * {{ADDR_W{1'b0}}, c_q};
  assign m_next_s   = {1'b0, m_q} + {1'b0, stride_q};
  assign c_last_s   = (c_q == C_LAST);
  assign c_marked_s = bitmap_q[c_q[IDX_W-1:0]];

  // State and datapath registers; async reset clears everything to the idle image.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      m_q      <= '0;
      stride_q <= '0;
      bitmap_q <= '0;
      prime_q  <= '0;
      pv_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      m_q      <= m_d;
      stride_q <= stride_d;
      bitmap_q <= bitmap_d;
      prime_q  <= prime_d;
      pv_q     <= pv_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic; everything holds when En is low.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    m_d      = m_q;
    stride_d = stride_q;
    bitmap_d = bitmap_q;
    prime_d  = prime_q;
    pv_d     = 1'b0;
    cnt_d    = cnt_q;

    if (En) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        S_CLEAR: begin
          bitmap_d = '0;
          c_d      = ADDR_W'(2);
          state_d  = S_SCAN;
        end
        S_SCAN: begin
          if (c_marked_s) begin
            if (c_last_s) begin
              state_d = S_DONE;
            end else begin
              c_d = c_q + ADDR_W'(1);
            end
          end else begin
            prime_d = c_q;
            pv_d    = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            // Multiples below c*c were already flagged by smaller primes.
            if (c_sq_s < N_SQ_CMP) begin
              m_d      = c_sq_s[ADDR_W-1:0];
              stride_d = c_q;
              state_d  = S_MARK;
            end else if (c_last_s) begin
              state_d = S_DONE;
            end else begin
              c_d = c_q + ADDR_W'(1);
            end
          end
        end
        S_MARK: begin
          bitmap_d[m_q[IDX_W-1:0]] = 1'b1;
          if (m_next_s < N_ADD_CMP) begin
            m_d = m_next_s[ADDR_W-1:0];
          end else if (c_last_s) begin
            state_d = S_DONE;
          end else begin
            c_d     = c_q + ADDR_W'(1);
            state_d = S_SCAN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      // Frozen: a pending pulse is kept and shows again once En returns.
      pv_d = pv_q;
    end

    busy_d = (state_d == S_CLEAR) || (state_d == S_SCAN) || (state_d == S_MARK);
    done_d = (state_d == S_DONE);
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign PrimeValid = pv_q & En;
  assign Prime      = prime_q;
  assign PrimeCount = cnt_q;

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for prime_sieve_ctrl: three instances (N=16, 32, 1024). Stimulus
// pushes expected {prime, count} pairs into a scoreboard queue. A negedge
// monitor pops and compares them on every PrimeValid pulse. Expected primes
// come from trial division. Expected run lengths are hand-computed, and for
// N=1024 they come from the closed-form mark count.
// -----------------------------------------------------------------------------
module tb_prime_sieve_ctrl;

  typedef struct packed {
    logic [9:0] p;
    logic [9:0] c;
  } exp_t;

  logic       Clock;
  logic       Reset_n;
  logic       start_s  [3];
  logic       en_s     [3];
  logic       busy_s   [3];
  logic       done_s   [3];
  logic       pvalid_s [3];
  logic [9:0] prime_s  [3];
  logic [9:0] pcount_s [3];

  exp_t sb_q[$];
  exp_t mon_e;
  int   busy_tot [3];
  int   checks;
  int   errors;

  prime_sieve_ctrl #(.N(16), .ADDR_W(10), .CNT_W(10)) u_n16 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_s[0]), .En(en_s[0]),
    .Busy(busy_s[0]), .Done(done_s[0]), .PrimeValid(pvalid_s[0]),
    .Prime(prime_s[0]), .PrimeCount(pcount_s[0]));

  prime_sieve_ctrl #(.N(32), .ADDR_W(10), .CNT_W(10)) u_n32 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_s[1]), .En(en_s[1]),
    .Busy(busy_s[1]), .Done(done_s[1]), .PrimeValid(pvalid_s[1]),
    .Prime(prime_s[1]), .PrimeCount(pcount_s[1]));

  prime_sieve_ctrl #(.N(1024), .ADDR_W(10), .CNT_W(10)) u_n1024 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(start_s[2]), .En(en_s[2]),
    .Busy(busy_s[2]), .Done(done_s[2]), .PrimeValid(pvalid_s[2]),
    .Prime(prime_s[2]), .PrimeCount(pcount_s[2]));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor: counts enabled Busy cycles and scores every PrimeValid pulse.
  initial begin
    busy_tot[0] = 0;
    busy_tot[1] = 0;
    busy_tot[2] = 0;
  end

  always @(negedge Clock) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_s[k] && en_s[k]) busy_tot[k] = busy_tot[k] + 1;
      if (busy_s[k] && done_s[k]) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL busy_done_overlap dut=%0d actual=both_high required=exclusive", k);
      end
      if (pvalid_s[k]) begin
        checks = checks + 1;
        if (!en_s[k]) begin
          errors = errors + 1;
          $display("FAIL pv_while_en_low dut=%0d actual=1 required=0", k);
        end else if (sb_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_prime dut=%0d actual=%0d required=none", k, prime_s[k]);
        end else begin
          mon_e = sb_q.pop_front();
          if (prime_s[k] != mon_e.p || pcount_s[k] != mon_e.c) begin
            errors = errors + 1;
            $display("FAIL prime_stream dut=%0d actual=%0d/#%0d required=%0d/#%0d",
                     k, prime_s[k], pcount_s[k], mon_e.p, mon_e.c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pushes the primes below n (trial division) and returns the total mark count.
  task automatic push_primes(input int n, output int marks);
    int cnt;
    bit isp;
    cnt   = 0;
    marks = 0;
    for (int v = 2; v < n; v++) begin
      isp = 1'b1;
      for (int d = 2; d * d <= v; d++) begin
        if (v % d == 0) isp = 1'b0;
      end
      if (isp) begin
        cnt = cnt + 1;
        sb_q.push_back({10'(v), 10'(cnt)});
        if (v * v < n) marks = marks + (n - 1 - v * v) / v + 1;
      end
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    chk({tag, "_busy"},  int'(busy_s[k]),   0);
    chk({tag, "_done"},  int'(done_s[k]),   0);
    chk({tag, "_pv"},    int'(pvalid_s[k]), 0);
    chk({tag, "_prime"}, int'(prime_s[k]),  0);
    chk({tag, "_count"}, int'(pcount_s[k]), 0);
  endtask

  task automatic run_sieve(input int k, input int exp_cnt, input int exp_last,
                           input int exp_busy, input bit rand_en, input bit pokes);
    int b0;
    int cyc;
    b0 = busy_tot[k];
    @(posedge Clock); #1;
    start_s[k] = 1'b1;
    en_s[k]    = 1'b1;
    @(posedge Clock); #1;
    start_s[k] = 1'b0;
    chk("busy_on_accept", int'(busy_s[k]), 1);
    chk("done_cleared", int'(done_s[k]), 0);
    chk("count_cleared", int'(pcount_s[k]), 0);
    cyc = 0;
    while (!done_s[k] && cyc < 20000) begin
      if (rand_en) en_s[k] = ($urandom_range(0, 3) != 0);
      else         en_s[k] = 1'b1;
      start_s[k] = pokes && (cyc == 4 || cyc == 16);
      @(posedge Clock); #1;
      cyc = cyc + 1;
    end
    en_s[k]    = 1'b1;
    start_s[k] = 1'b0;
    chk("run_timeout", int'(done_s[k]), 1);
    chk("final_prime", int'(prime_s[k]), exp_last);
    chk("final_count", int'(pcount_s[k]), exp_cnt);
    @(negedge Clock); #1;
    chk("busy_cycles", busy_tot[k] - b0, exp_busy);
    chk("busy_after_done", int'(busy_s[k]), 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(posedge Clock);
    #1;
    chk("done_held", int'(done_s[k]), 1);
    chk("count_held", int'(pcount_s[k]), exp_cnt);
  endtask

  initial begin
    int m;
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      en_s[k]    = 1'b1;
    end
    #12;
    for (int k = 0; k < 3; k++) check_idle_outputs(k, "reset");
    @(negedge Clock);
    Reset_n = 1'b1;

    // N=16: primes 2..13, Busy = 1 + 14 + 9.
    push_primes(16, m);
    run_sieve(0, 6, 13, 24, 1'b0, 1'b0);

    // N=32 plain, with random En, and with Start pokes (second run from DONE).
    push_primes(32, m);
    run_sieve(1, 11, 31, 55, 1'b0, 1'b0);
    push_primes(32, m);
    run_sieve(1, 11, 31, 55, 1'b1, 1'b0);
    push_primes(32, m);
    run_sieve(1, 11, 31, 55, 1'b0, 1'b1);

    // Reset while marking multiples of 3 (enabled cycles 18..25 after accept).
    push_primes(32, m);
    @(posedge Clock); #1;
    start_s[1] = 1'b1;
    @(posedge Clock); #1;
    start_s[1] = 1'b0;
    repeat (20) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    check_idle_outputs(1, "midmark_reset");
    chk("primes_left_at_reset", sb_q.size(), 9);
    sb_q.delete();
    @(negedge Clock);
    Reset_n = 1'b1;

    // Full run after the reset must not see stale marks.
    push_primes(32, m);
    run_sieve(1, 11, 31, 55, 1'b0, 1'b0);

    // Default size.
    push_primes(1024, m);
    run_sieve(2, 172, 1021, 1 + 1022 + m, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
